// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, debug-loaded word-addressed instruction memory
// and the IF/ID pipeline register feeding the decode stage.
module if_stage #(
    parameter int                  PC_WIDTH   = 32,
    parameter int                  DATA_WIDTH = 32,
    parameter int                  IMEM_DEPTH = 256,
    parameter logic [DATA_WIDTH-1:0] HALT_INSTR = 32'hFFFF_FFFF,
    localparam int                 AW         = $clog2(IMEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [PC_WIDTH-1:0]   branch_target,
    input  logic                  jump,
    input  logic [PC_WIDTH-1:0]   jump_target,
    input  logic                  dbg_we,
    input  logic [AW-1:0]         dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic [DATA_WIDTH-1:0] if_id_instr,
    output logic [PC_WIDTH-1:0]   if_id_pc_plus4,
    output logic                  if_id_valid,
    output logic [PC_WIDTH-1:0]   pc,
    output logic                  halted,
    output logic [31:0]           instr_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [PC_WIDTH-1:0]   pc4_q, pc4_d;
    logic                  valid_q, valid_d;
    logic [31:0]           count_q, count_d;

    logic [DATA_WIDTH-1:0] imem [IMEM_DEPTH];
    logic [DATA_WIDTH-1:0] fetched;
    logic [PC_WIDTH-1:0]   pc_plus4;

    // Upper PC bits alias onto the memory; the byte offset is ignored.
    assign fetched  = imem[pc_q[AW+1:2]];
    assign pc_plus4 = pc_q + PC_WIDTH'(4);

    // Loading is only allowed before the run starts, independent of enable.
    always_ff @(posedge clk) begin
        if (dbg_we && state_q == IDLE) begin
            imem[dbg_addr] <= dbg_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        count_d = count_q;
        if (enable) begin
            case (state_q)
                IDLE: begin
                    state_d = RUN;
                end
                RUN: begin
                    if (stall) begin
                        state_d = RUN;
                    end else if (jump || branch_taken) begin
                        // Wrong-path flush; a HALT fetched here is discarded too.
                        pc_d    = jump ? jump_target : branch_target;
                        instr_d = '0;
                        pc4_d   = '0;
                        valid_d = 1'b0;
                    end else if (fetched == HALT_INSTR) begin
                        instr_d = fetched;
                        pc4_d   = pc_plus4;
                        valid_d = 1'b1;
                        count_d = count_q + 32'd1;
                        state_d = HALTED;
                    end else begin
                        pc_d    = pc_plus4;
                        instr_d = fetched;
                        pc4_d   = pc_plus4;
                        valid_d = 1'b1;
                        count_d = count_q + 32'd1;
                    end
                end
                HALTED: begin
                    instr_d = '0;
                    pc4_d   = '0;
                    valid_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign if_id_instr    = instr_q;
    assign if_id_pc_plus4 = pc4_q;
    assign if_id_valid    = valid_q;
    assign pc             = pc_q;
    assign halted         = (state_q == HALTED);
    assign instr_count    = count_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: fetch sequence, stall, redirects, HALT, debug
// writes in RUN, mid-run reset and PC wrap.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        dbg_we;
    logic [7:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic [31:0] pc;
    logic        halted;
    logic [31:0] instr_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump           (jump),
        .jump_target    (jump_target),
        .dbg_we         (dbg_we),
        .dbg_addr       (dbg_addr),
        .dbg_wdata      (dbg_wdata),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .pc             (pc),
        .halted         (halted),
        .instr_count    (instr_count)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [7:0] a, input logic [31:0] d);
        dbg_we    = 1'b1;
        dbg_addr  = a;
        dbg_wdata = d;
        tick();
        dbg_we    = 1'b0;
    endtask

    function automatic logic [31:0] word(input int i);
        return 32'h1000_0000 + 32'(i);
    endfunction

    initial begin
        reset = 1'b0; enable = 1'b0; stall = 1'b0;
        branch_taken = 1'b0; branch_target = '0;
        jump = 1'b0; jump_target = '0;
        dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        tick(); tick();
        check_eq("rst_pc", pc, 0);
        check_eq("rst_valid", if_id_valid, 0);
        check_eq("rst_instr", if_id_instr, 0);
        check_eq("rst_halted", halted, 0);
        check_eq("rst_count", instr_count, 0);

        reset = 1'b1;
        for (int i = 0; i < 256; i++) load_word(8'(i), word(i));

        // IDLE -> RUN takes one enabled edge with no fetch
        enable = 1'b1;
        tick();
        check_eq("idle_pc", pc, 0);
        check_eq("idle_valid", if_id_valid, 0);
        tick();
        check_eq("f0_instr", if_id_instr, word(0));
        check_eq("f0_pc", pc, 32'h4);
        check_eq("f0_pc4", if_id_pc_plus4, 32'h4);
        check_eq("f0_count", instr_count, 1);
        tick();
        check_eq("f1_instr", if_id_instr, word(1));
        check_eq("f1_pc", pc, 32'h8);
        check_eq("f1_count", instr_count, 2);

        // stall with a concurrent branch: nothing moves
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
        for (int k = 0; k < 2; k++) begin
            tick();
            check_eq("stall_pc", pc, 32'h8);
            check_eq("stall_instr", if_id_instr, word(1));
            check_eq("stall_count", instr_count, 2);
        end
        stall = 1'b0; branch_taken = 1'b0;
        tick();
        check_eq("f2_instr", if_id_instr, word(2));
        check_eq("f2_pc", pc, 32'hC);
        check_eq("f2_count", instr_count, 3);

        branch_taken = 1'b1; branch_target = 32'h40;
        tick();
        branch_taken = 1'b0;
        check_eq("br_pc", pc, 32'h40);
        check_eq("br_valid", if_id_valid, 0);
        check_eq("br_instr", if_id_instr, 0);
        check_eq("br_count", instr_count, 3);
        tick();
        check_eq("br_tgt_instr", if_id_instr, word(16));
        check_eq("br_tgt_pc4", if_id_pc_plus4, 32'h44);
        check_eq("br_tgt_count", instr_count, 4);

        jump = 1'b1; jump_target = 32'h80; branch_taken = 1'b1; branch_target = 32'h40;
        tick();
        jump = 1'b0; branch_taken = 1'b0;
        check_eq("jmp_pri_pc", pc, 32'h80);
        check_eq("jmp_valid", if_id_valid, 0);
        tick();
        check_eq("jmp_tgt_instr", if_id_instr, word(32));
        check_eq("jmp_tgt_count", instr_count, 5);

        // debug write to the next fetch address while running must be ignored
        dbg_we = 1'b1; dbg_addr = 8'd34; dbg_wdata = 32'hDEAD_BEEF;
        tick();
        dbg_we = 1'b0;
        check_eq("run_we_instr33", if_id_instr, word(33));
        tick();
        check_eq("run_we_instr34", if_id_instr, word(34));
        check_eq("run_we_count", instr_count, 7);

        jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        tick();
        jump = 1'b0;
        check_eq("wrap_pre_pc", pc, 32'hFFFF_FFFC);
        tick();
        check_eq("wrap_pc", pc, 0);
        check_eq("wrap_pc4", if_id_pc_plus4, 0);
        check_eq("wrap_instr", if_id_instr, word(255));
        check_eq("wrap_count", instr_count, 8);

        reset = 1'b0;
        tick();
        check_eq("mid_rst_pc", pc, 0);
        check_eq("mid_rst_instr", if_id_instr, 0);
        check_eq("mid_rst_valid", if_id_valid, 0);
        check_eq("mid_rst_count", instr_count, 0);
        check_eq("mid_rst_halted", halted, 0);

        reset = 1'b1; enable = 1'b0;
        load_word(8'd2, 32'hFFFF_FFFF);
        load_word(8'd5, 32'hFFFF_FFFF);
        enable = 1'b1;
        tick();
        tick();
        check_eq("r2_f0_instr", if_id_instr, word(0));
        enable = 1'b0; jump = 1'b1; jump_target = 32'h80;
        tick();
        jump = 1'b0;
        check_eq("en0_pc", pc, 32'h4);
        check_eq("en0_instr", if_id_instr, word(0));
        check_eq("en0_count", instr_count, 1);
        enable = 1'b1;
        tick();
        check_eq("r2_f1_pc", pc, 32'h8);

        // HALT sits at pc=8; a simultaneous branch discards it
        branch_taken = 1'b1; branch_target = 32'h10;
        tick();
        branch_taken = 1'b0;
        check_eq("halt_disc_halted", halted, 0);
        check_eq("halt_disc_pc", pc, 32'h10);
        check_eq("halt_disc_valid", if_id_valid, 0);
        tick();
        check_eq("r2_f4_instr", if_id_instr, word(4));
        check_eq("r2_f4_pc", pc, 32'h14);
        tick();
        check_eq("halt_instr", if_id_instr, 32'hFFFF_FFFF);
        check_eq("halt_valid", if_id_valid, 1);
        check_eq("halt_flag", halted, 1);
        check_eq("halt_pc", pc, 32'h14);
        check_eq("halt_count", instr_count, 4);
        jump = 1'b1; jump_target = 32'h80;
        tick();
        jump = 1'b0;
        check_eq("hlt_bub_instr", if_id_instr, 0);
        check_eq("hlt_bub_valid", if_id_valid, 0);
        check_eq("hlt_bub_pc", pc, 32'h14);
        check_eq("hlt_bub_count", instr_count, 4);
        check_eq("hlt_bub_halted", halted, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
